data_memory_lat: RTL and testbench

Parametrised data memory that replaces the fixed 8-word, single-cycle CPU data memory. It adds configurable width, depth and access latency, a req/ack handshake, byte-enable writes, and error reporting for misaligned or out-of-range addresses. It sits behind the MEM stage: the pipeline holds its stall while busy_o is high, and it consumes the result when ack_o pulses.

---
 rtl/data_memory_lat_pkg.sv | 26 ++
 rtl/data_memory_lat_if.sv | 33 +++
 rtl/data_memory_lat_dmem_array.sv | 37 +++
 rtl/data_memory_lat.sv | 114 +++++++++++
 tb/tb_data_memory_lat.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_lat_pkg.sv
// Shared definitions for the latency-configurable data memory: FSM encoding,
// default geometry and helpers deriving address field widths.
package data_memory_lat_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Byte-offset bits inside one word.
    function automatic int wb_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Word-index bits for the array.
    function automatic int iw_of(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/data_memory_lat_if.sv
// Request/response bus between the MEM stage and the data memory.
interface data_memory_lat_if
    import data_memory_lat_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    // Handshake: the master raises req_i with we_i/addr_i/data_i/be_i and holds
    // them until ack_o pulses for one cycle; a request is taken only when the
    // slave is idle or acking (busy_o low), and err_o/data_o are meaningful
    // in the ack_o cycle (data_o then holds until the next read ack).
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     data_i;
    logic [DATA_W/8-1:0]   be_i;
    logic                  busy_o;
    logic                  ack_o;
    logic                  err_o;
    logic [DATA_W-1:0]     data_o;

    modport master (
        output req_i, we_i, addr_i, data_i, be_i,
        input  busy_o, ack_o, err_o, data_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i, be_i,
        output busy_o, ack_o, err_o, data_o
    );

endinterface

// File: rtl/data_memory_lat_dmem_array.sv
// Byte-enabled synchronous-write, registered-read word storage; kept apart from
// the handshake so it can be replaced by an SRAM macro.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int IW    = $clog2(DEPTH),
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [IW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents survive reset; only an in-flight write is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be[k]) mem[idx][k*8 +: 8] <= wdata[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)      rdata <= '0;
        else if (clr) rdata <= '0;
        else if (re)  rdata <= mem[idx];
    end

endmodule

// File: rtl/data_memory_lat.sv
// Data memory with configurable access latency, req/ack handshake, byte-enable
// writes and misaligned/out-of-range error reporting.
module data_memory_lat
    import data_memory_lat_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst_i,
    data_memory_lat_if.slave  bus,
    output state_t            state
);

    localparam int WB   = wb_of(DATA_W);
    localparam int IW   = iw_of(DEPTH);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              accept, live_err, enter_resp, use_latched;
    logic [IW-1:0]     idx_q, c_idx;
    logic [DATA_W-1:0] wdata_q, c_wdata;
    logic [BE_W-1:0]   be_q, c_be;
    logic              we_q, err_lat_q, c_we, c_err, err_q;

    assign accept   = bus.req_i && (state_q == S_IDLE || state_q == S_RESP);
    assign live_err = (bus.addr_i[WB-1:0] != '0) || (bus.addr_i[ADDR_W-1:WB+IW] != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With LATENCY==1 the commit edge is also the accept edge, so the live bus
    // values are used; otherwise the values latched at acceptance.
    assign use_latched = (state_q == S_WAIT);
    assign c_idx   = use_latched ? idx_q     : bus.addr_i[WB+IW-1:WB];
    assign c_wdata = use_latched ? wdata_q   : bus.data_i;
    assign c_be    = use_latched ? be_q      : bus.be_i;
    assign c_we    = use_latched ? we_q      : bus.we_i;
    assign c_err   = use_latched ? err_lat_q : live_err;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            err_lat_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= enter_resp ? c_err : 1'b0;
            if (accept) begin
                idx_q     <= bus.addr_i[WB+IW-1:WB];
                wdata_q   <= bus.data_i;
                be_q      <= bus.be_i;
                we_q      <= bus.we_i;
                err_lat_q <= live_err;
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst_i),
        .we    (enter_resp && c_we && !c_err),
        .re    (enter_resp && !c_we && !c_err),
        .clr   (enter_resp && c_err),
        .idx   (c_idx),
        .wdata (c_wdata),
        .be    (c_be),
        .rdata (bus.data_o)
    );

    assign bus.busy_o = (state_q == S_WAIT);
    assign bus.ack_o  = (state_q == S_RESP);
    assign bus.err_o  = err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_data_memory_lat.sv
// Bench for data_memory_lat: a LATENCY=4 and a LATENCY=1 instance checked
// against a reference memory model through per-instance expectation queues.
module tb_data_memory_lat;
    import data_memory_lat_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    data_memory_lat_if #(.DATA_W(32), .ADDR_W(32)) if4 ();
    data_memory_lat_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
    state_t state4, state1;

    data_memory_lat #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(4)) dut4 (
        .clk(clk), .rst_i(rst_i), .bus(if4.slave), .state(state4)
    );
    data_memory_lat #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst_i(rst_i), .bus(if1.slave), .state(state1)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] due;
    } exp_t;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    exp_t        e0, e1;
    logic [31:0] mem_m [2][256];
    logic [31:0] exp_dout [2];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (if4.ack_o) begin
                if (exp_q0.size() == 0) begin
                    check_eq("l4_unexpected_ack", 32'(if4.ack_o), 0);
                end else begin
                    e0 = exp_q0.pop_front();
                    check_eq("l4_data", if4.data_o, e0.data);
                    check_eq("l4_err", 32'(if4.err_o), 32'(e0.err));
                    check_eq("l4_ack_cycle", 32'(cyc), e0.due);
                end
            end else begin
                check_eq("l4_err_no_ack", 32'(if4.err_o), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_i) begin
            check_eq("l1_busy", 32'(if1.busy_o), 0);
            if (if1.ack_o) begin
                if (exp_q1.size() == 0) begin
                    check_eq("l1_unexpected_ack", 32'(if1.ack_o), 0);
                end else begin
                    e1 = exp_q1.pop_front();
                    check_eq("l1_data", if1.data_o, e1.data);
                    check_eq("l1_err", 32'(if1.err_o), 32'(e1.err));
                    check_eq("l1_ack_cycle", 32'(cyc), e1.due);
                end
            end else begin
                check_eq("l1_err_no_ack", 32'(if1.err_o), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic int lat(input int which);
        return (which == 0) ? 4 : 1;
    endfunction

    task automatic drive(input int which, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        if (which == 0) begin
            if4.req_i = req; if4.we_i = we; if4.addr_i = addr; if4.data_i = data; if4.be_i = be;
        end else begin
            if1.req_i = req; if1.we_i = we; if1.addr_i = addr; if1.data_i = data; if1.be_i = be;
        end
    endtask

    task automatic push_exp(input int which, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be, input int due);
        logic        err;
        logic [31:0] d;
        int          idx;
        exp_t        e;
        err = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
        idx = int'(addr[9:2]);
        if (err) begin
            d = 32'd0;
        end else if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem_m[which][idx][k*8 +: 8] = data[k*8 +: 8];
            end
            d = exp_dout[which];
        end else begin
            d = mem_m[which][idx];
        end
        exp_dout[which] = d;
        e.data = d;
        e.err  = err;
        e.due  = 32'(due);
        if (which == 0) exp_q0.push_back(e);
        else            exp_q1.push_back(e);
    endtask

    task automatic start(input int which, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be, input int due);
        drive(which, 1'b1, we, addr, data, be);
        push_exp(which, we, addr, data, be, due);
    endtask

    task automatic wait_ack(input int which, input logic drop);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? if4.ack_o : if1.ack_o;
            if (!seen && which == 0) check_eq("l4_busy_in_wait", 32'(if4.busy_o), 1);
        end
        if (!seen) check_eq("ack_timeout", 32'(seen), 1);
        if (drop) drive(which, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic access(input int which, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
        start(which, we, addr, data, be, cyc + lat(which));
        wait_ack(which, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int due_a;
        for (int w = 0; w < 2; w++) begin
            exp_dout[w] = 32'd0;
            for (int i = 0; i < 256; i++) mem_m[w][i] = 32'd0;
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        check_eq("rst_busy4", 32'(if4.busy_o), 0);
        check_eq("rst_ack4", 32'(if4.ack_o), 0);
        check_eq("rst_err4", 32'(if4.err_o), 0);
        check_eq("rst_data4", if4.data_o, 0);
        check_eq("rst_state4", 32'(state4), 32'(S_IDLE));
        check_eq("rst_busy1", 32'(if1.busy_o), 0);
        check_eq("rst_ack1", 32'(if1.ack_o), 0);
        check_eq("rst_data1", if1.data_o, 0);
        check_eq("rst_state1", 32'(state1), 32'(S_IDLE));

        // Preload 16 words in both instances.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) access(w, 1'b1, 32'(i * 4), $urandom, 4'hF);
        end

        // Write then read.
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0);

        // Byte enables, then an all-zero enable write.
        access(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
        access(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        access(0, 1'b0, 32'h20, 32'h0, 4'h0);
        access(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
        access(0, 1'b0, 32'h20, 32'h0, 4'h0);

        // Misaligned and out-of-range accesses.
        access(0, 1'b1, 32'h0, 32'h0102_0304, 4'hF);
        access(0, 1'b0, 32'h0, 32'h0, 4'h0);
        access(0, 1'b0, 32'h12, 32'h0, 4'h0);
        access(0, 1'b1, 32'h400, 32'h9999_9999, 4'hF);
        access(0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Back-to-back reads on the single-cycle instance.
        access(1, 1'b1, 32'h0, 32'hA0A0_0000, 4'hF);
        access(1, 1'b1, 32'h4, 32'hA0A0_0004, 4'hF);
        access(1, 1'b1, 32'h8, 32'hA0A0_0008, 4'hF);
        start(1, 1'b0, 32'h0, 32'h0, 4'h0, cyc + 1);
        wait_ack(1, 1'b0);
        start(1, 1'b0, 32'h4, 32'h0, 4'h0, cyc + 1);
        wait_ack(1, 1'b0);
        start(1, 1'b0, 32'h8, 32'h0, 4'h0, cyc + 1);
        wait_ack(1, 1'b1);

        // Reset during WAIT aborts the write.
        access(0, 1'b1, 32'h30, 32'hCAFE_0001, 4'hF);
        access(0, 1'b0, 32'h30, 32'h0, 4'h0);
        drive(0, 1'b1, 1'b1, 32'h30, 32'h5555_5555, 4'hF);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        rst_i = 1'b0;
        exp_dout[0] = 32'd0;
        exp_dout[1] = 32'd0;
        check_eq("abort_busy", 32'(if4.busy_o), 0);
        check_eq("abort_ack", 32'(if4.ack_o), 0);
        check_eq("abort_err", 32'(if4.err_o), 0);
        check_eq("abort_data", if4.data_o, 0);
        check_eq("abort_state", 32'(state4), 32'(S_IDLE));
        repeat (6) @(negedge clk);
        access(0, 1'b0, 32'h30, 32'h0, 4'h0);

        // Second request presented during WAIT waits for the RESP cycle.
        due_a = cyc + 4;
        start(0, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, due_a);
        repeat (2) @(negedge clk);
        start(0, 1'b1, 32'h44, 32'h7777_8888, 4'hF, due_a + 4);
        wait_ack(0, 1'b0);
        wait_ack(0, 1'b1);
        access(0, 1'b0, 32'h40, 32'h0, 4'h0);
        access(0, 1'b0, 32'h44, 32'h0, 4'h0);

        // Random mix on both instances.
        for (int n = 0; n < 40; n++) begin
            int          w;
            logic [31:0] a;
            w = $urandom_range(0, 1);
            a = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'd2;
            if ($urandom_range(0, 9) == 0) a = a | 32'h0000_1000;
            access(w, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        repeat (8) @(negedge clk);
        check_eq("drain_q4", 32'(exp_q0.size()), 0);
        check_eq("drain_q1", 32'(exp_q1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
